pit_table: RTL and testbench

//  Pending Interest Table stage, directly downstream of the FIB data path. Records incoming

---
 rtl/pit_table.sv | 231 +++++++++++++++++++++++
 tb/tb_pit_table.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_table.sv
// Pending Interest Table: records Interests by hashed name, forwards new names to the FIB,
// answers FIB data lookups and streams the matching data packet to the requesting faces.
module pit_table #(
  parameter int unsigned NUM_FACES  = 4,
  parameter int unsigned DATA_BYTES = 1024,
  parameter int unsigned HASH_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 int_valid,
  input  logic [63:0]          int_prefix,
  input  logic [5:0]           int_len,
  input  logic [NUM_FACES-1:0] int_face,
  output logic                 int_ready,
  output logic                 int_nack,
  output logic                 fib_out_bit,
  output logic [63:0]          fib_prefix,
  output logic [5:0]           fib_len,
  input  logic                 prefix_ready,
  input  logic [63:0]          data_prefix,
  input  logic [5:0]           data_len,
  output logic                 start_send_to_pit,
  output logic                 rejected,
  input  logic [7:0]           data_in,
  output logic                 out_valid,
  output logic [7:0]           out_byte,
  output logic [NUM_FACES-1:0] out_faces,
  output logic                 out_last
);

  localparam int unsigned Depth   = 2 ** HASH_W;
  localparam int unsigned CntW    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned TagW    = 70;
  localparam int unsigned NSlice  = (64 + HASH_W - 1) / HASH_W;
  localparam int unsigned PadW    = NSlice * HASH_W;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIHash,
    StIUpd,
    StIFwd,
    StDHash,
    StDChk,
    StDStrm
  } state_e;

  // Name = prefix with every bit at or above len cleared.
  function automatic logic [63:0] name_mask(input logic [63:0] p, input logic [5:0] l);
    logic [63:0] keep;
    keep = ~({64{1'b1}} << l);
    return p & keep;
  endfunction

  // XOR-fold of the masked name in HASH_W slices (last slice zero padded), mixed with len.
  function automatic logic [HASH_W-1:0] name_hash(input logic [63:0] p, input logic [5:0] l);
    logic [PadW-1:0]   padded;
    logic [HASH_W-1:0] h;
    padded = PadW'(name_mask(p, l));
    h      = HASH_W'(l);
    for (int s = 0; s < int'(NSlice); s++) begin
      h = h ^ padded[s*HASH_W +: HASH_W];
    end
    return h;
  endfunction

  state_e                state_q, state_d;
  logic [63:0]           cap_prefix_q, cap_prefix_d;
  logic [5:0]            cap_len_q, cap_len_d;
  logic [NUM_FACES-1:0]  cap_face_q, cap_face_d;
  logic [HASH_W-1:0]     h_q, h_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            out_byte_q, out_byte_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [NUM_FACES-1:0]  out_faces_q, out_faces_d;
  logic                  int_ready_q, int_ready_d;
  logic [Depth-1:0]      valid_q, valid_d;

  logic [TagW-1:0]       tag_mem [Depth];
  logic [NUM_FACES-1:0]  bm_mem  [Depth];

  logic                  tbl_we;
  logic [NUM_FACES-1:0]  tbl_wbm;
  logic [TagW-1:0]       cur_tag;
  logic                  rd_valid;
  logic                  tag_hit;
  logic [NUM_FACES-1:0]  rd_bm;

  assign cur_tag  = {name_mask(cap_prefix_q, cap_len_q), cap_len_q};
  assign rd_valid = valid_q[h_q];
  assign rd_bm    = bm_mem[h_q];
  assign tag_hit  = rd_valid && (tag_mem[h_q] == cur_tag);

  assign int_ready  = int_ready_q;
  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign out_faces  = out_faces_q;
  assign out_last   = out_last_q;
  assign fib_prefix = fib_out_bit ? cap_prefix_q : 64'd0;
  assign fib_len    = fib_out_bit ? cap_len_q : 6'd0;

  // Next-state, table update and pulse outputs.
  always_comb begin
    state_d           = state_q;
    cap_prefix_d      = cap_prefix_q;
    cap_len_d         = cap_len_q;
    cap_face_d        = cap_face_q;
    h_d               = h_q;
    cnt_d             = cnt_q;
    out_byte_d        = out_byte_q;
    out_valid_d       = 1'b0;
    out_last_d        = 1'b0;
    out_faces_d       = out_faces_q;
    int_ready_d       = 1'b0;
    valid_d           = valid_q;
    tbl_we            = 1'b0;
    tbl_wbm           = cap_face_q;
    int_nack          = 1'b0;
    fib_out_bit       = 1'b0;
    start_send_to_pit = 1'b0;
    rejected          = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Data lookups win so the FIB stream is never stalled behind an Interest.
        if (prefix_ready) begin
          cap_prefix_d = data_prefix;
          cap_len_d    = data_len;
          state_d      = StDHash;
        end else if (int_valid) begin
          int_ready_d  = 1'b1;
          cap_prefix_d = int_prefix;
          cap_len_d    = int_len;
          cap_face_d   = int_face;
          state_d      = StIHash;
        end
      end
      StIHash: begin
        h_d     = name_hash(cap_prefix_q, cap_len_q);
        state_d = StIUpd;
      end
      StIUpd: begin
        if (!rd_valid) begin
          tbl_we       = 1'b1;
          tbl_wbm      = cap_face_q;
          valid_d[h_q] = 1'b1;
          state_d      = StIFwd;
        end else if (tag_hit) begin
          // Aggregate: same name already pending, just add the face.
          tbl_we  = 1'b1;
          tbl_wbm = rd_bm | cap_face_q;
          state_d = StIdle;
        end else begin
          int_nack = 1'b1;
          state_d  = StIdle;
        end
      end
      StIFwd: begin
        fib_out_bit = 1'b1;
        state_d     = StIdle;
      end
      StDHash: begin
        h_d     = name_hash(cap_prefix_q, cap_len_q);
        state_d = StDChk;
      end
      StDChk: begin
        if (tag_hit) begin
          start_send_to_pit = 1'b1;
          out_faces_d       = rd_bm;
          cnt_d             = '0;
          state_d           = StDStrm;
        end else begin
          rejected = 1'b1;
          state_d  = StIdle;
        end
      end
      StDStrm: begin
        out_byte_d  = data_in;
        out_valid_d = 1'b1;
        cnt_d       = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          out_last_d   = 1'b1;
          valid_d[h_q] = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers; reset clears every entry's valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cap_prefix_q <= '0;
      cap_len_q    <= '0;
      cap_face_q   <= '0;
      h_q          <= '0;
      cnt_q        <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_faces_q  <= '0;
      int_ready_q  <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cap_prefix_q <= cap_prefix_d;
      cap_len_q    <= cap_len_d;
      cap_face_q   <= cap_face_d;
      h_q          <= h_d;
      cnt_q        <= cnt_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_faces_q  <= out_faces_d;
      int_ready_q  <= int_ready_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and face bitmap storage; only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tag_mem[h_q] <= cur_tag;
      bm_mem[h_q]  <= tbl_wbm;
    end
  end

endmodule

// File: tb/tb_pit_table.sv
// Self-checking bench for pit_table: directed scenarios plus a randomized mix of Interests
// and data lookups, checked against a name-keyed reference model of the table.
module tb_pit_table;

  localparam int NF = 4;
  localparam int DB = 1024;
  localparam int HW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          int_valid;
  logic [63:0]   int_prefix;
  logic [5:0]    int_len;
  logic [NF-1:0] int_face;
  logic          int_ready, int_nack, fib_out_bit;
  logic [63:0]   fib_prefix;
  logic [5:0]    fib_len;
  logic          prefix_ready;
  logic [63:0]   data_prefix;
  logic [5:0]    data_len;
  logic          start_send_to_pit, rejected;
  logic [7:0]    data_in;
  logic          out_valid;
  logic [7:0]    out_byte;
  logic [NF-1:0] out_faces;
  logic          out_last;

  always #5 clk = ~clk;

  pit_table #(.NUM_FACES(NF), .DATA_BYTES(DB), .HASH_W(HW)) dut (
    .clk              (clk),
    .rst              (rst),
    .int_valid        (int_valid),
    .int_prefix       (int_prefix),
    .int_len          (int_len),
    .int_face         (int_face),
    .int_ready        (int_ready),
    .int_nack         (int_nack),
    .fib_out_bit      (fib_out_bit),
    .fib_prefix       (fib_prefix),
    .fib_len          (fib_len),
    .prefix_ready     (prefix_ready),
    .data_prefix      (data_prefix),
    .data_len         (data_len),
    .start_send_to_pit(start_send_to_pit),
    .rejected         (rejected),
    .data_in          (data_in),
    .out_valid        (out_valid),
    .out_byte         (out_byte),
    .out_faces        (out_faces),
    .out_last         (out_last)
  );

  int checks = 0;
  int errors = 0;

  // Reference table: one slot per hash value holding the pending name and its faces.
  bit            m_valid [1 << HW];
  logic [63:0]   m_pfx   [1 << HW];
  logic [5:0]    m_len   [1 << HW];
  logic [NF-1:0] m_bm    [1 << HW];

  function automatic logic [63:0] ref_mask(input logic [63:0] p, input logic [5:0] l);
    return p % (64'd1 << l);
  endfunction

  function automatic int ref_hash(input logic [63:0] p, input logic [5:0] l);
    logic [63:0] m;
    int h;
    m = ref_mask(p, l);
    h = int'(l);
    for (int k = 0; k < 7; k++) h = h ^ int'((m >> (10 * k)) & 64'd1023);
    return h;
  endfunction

  // Returns 0 = new name, 1 = aggregated, 2 = slot held by another name.
  function automatic int model_interest(input logic [63:0] p, input logic [5:0] l,
                                        input logic [NF-1:0] f);
    int h;
    h = ref_hash(p, l);
    if (!m_valid[h]) begin
      m_valid[h] = 1'b1;
      m_pfx[h]   = ref_mask(p, l);
      m_len[h]   = l;
      m_bm[h]    = f;
      return 0;
    end else if (m_pfx[h] == ref_mask(p, l) && m_len[h] == l) begin
      m_bm[h] = m_bm[h] | f;
      return 1;
    end
    return 2;
  endfunction

  function automatic bit model_hit(input logic [63:0] p, input logic [5:0] l,
                                   output logic [NF-1:0] bm);
    int h;
    h  = ref_hash(p, l);
    bm = m_bm[h];
    return m_valid[h] && m_pfx[h] == ref_mask(p, l) && m_len[h] == l;
  endfunction

  function automatic logic [7:0] pat(input int i, input logic [7:0] off, input int mul);
    return 8'(i * mul + int'(off));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{int_ready, int_nack, fib_out_bit, fib_prefix, fib_len, start_send_to_pit,
             rejected, out_valid, out_byte, out_faces, out_last};
  endfunction

  // Entered and left just after a rising edge.
  task automatic do_interest(input logic [63:0] p, input logic [5:0] l, input logic [NF-1:0] f);
    int kind, ready_at, nack_at, fib_at;
    logic [63:0] fp;
    logic [5:0]  fl;
    ready_at = -1; nack_at = -1; fib_at = -1; fp = '0; fl = '0;
    kind = model_interest(p, l, f);
    int_valid = 1'b1; int_prefix = p; int_len = l; int_face = f;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (int_ready && ready_at < 0) ready_at = k;
      if (int_nack && nack_at < 0) nack_at = k;
      if (fib_out_bit && fib_at < 0) begin
        fib_at = k; fp = fib_prefix; fl = fib_len;
      end
      @(posedge clk); #1;
      if (ready_at >= 0) begin
        int_valid  = 1'b0;
        int_prefix = {$urandom, $urandom};
        int_len    = 6'($urandom);
        int_face   = NF'($urandom);
      end
    end
    int_valid = 1'b0;
    chk("int_ready_at", ready_at, 1);
    chk("int_nack_at", nack_at, (kind == 2) ? 2 : -1);
    chk("fib_out_at", fib_at, (kind == 0) ? 3 : -1);
    if (kind == 0) begin
      chk("fib_prefix", longint'(fp), longint'(p));
      chk("fib_len", fl, l);
    end
  endtask

  task automatic do_lookup(input logic [63:0] p, input logic [5:0] l, input logic [7:0] off,
                           input int mul, input int abort_at);
    bit hit, aborted;
    logic [NF-1:0] ebm, fo;
    int kmax, start_at, rej_at, first_v, last_at, nv, bad, i;
    hit = model_hit(p, l, ebm);
    kmax = hit ? DB + 6 : 6;
    start_at = -1; rej_at = -1; first_v = -1; last_at = -1; nv = 0; bad = 0; fo = '0;
    aborted = 1'b0;
    prefix_ready = 1'b1; data_prefix = p; data_len = l; data_in = 8'($urandom);
    for (int k = 0; k < kmax; k++) begin
      @(negedge clk);
      if (start_send_to_pit && start_at < 0) start_at = k;
      if (rejected && rej_at < 0) rej_at = k;
      if (out_last && !out_valid) bad++;
      if (out_valid) begin
        nv++;
        if (first_v < 0) first_v = k;
        if (out_byte !== pat(k - 4, off, mul)) bad++;
        if (out_last) last_at = k;
      end
      if (k == 3) fo = out_faces;
      @(posedge clk); #1;
      prefix_ready = 1'b0;
      data_prefix  = {$urandom, $urandom};
      i = k + 1 - 3;
      data_in = (i >= 0 && i < DB) ? pat(i, off, mul) : 8'($urandom);
      if (abort_at >= 0 && k + 1 == 4 + abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_outputs_zero", any_out(), 0);
        chk("abort_bytes_before", nv, abort_at);
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      for (int h = 0; h < (1 << HW); h++) m_valid[h] = 1'b0;
      return;
    end
    if (hit) begin
      chk("start_at", start_at, 2);
      chk("rej_on_hit", rej_at, -1);
      chk("first_valid_at", first_v, 4);
      chk("valid_count", nv, DB);
      chk("last_at", last_at, DB + 3);
      chk("bad_bytes", bad, 0);
      chk("out_faces", fo, ebm);
      m_valid[ref_hash(p, l)] = 1'b0;
    end else begin
      chk("rejected_at", rej_at, 2);
      chk("start_on_miss", start_at, -1);
      chk("valid_on_miss", nv, 0);
    end
  endtask

  logic [63:0]   p_pool [6];
  logic [5:0]    l_pool [6];
  int            pk, p_rej, p_start, p_ready, p_fib, idx;
  logic [NF-1:0] pbm;
  bit            phit;

  initial begin
    rst = 1'b1; int_valid = 1'b0; int_prefix = '0; int_len = '0; int_face = '0;
    prefix_ready = 1'b0; data_prefix = '0; data_len = '0; data_in = '0;
    p_pool[0] = 64'h1234;                            l_pool[0] = 6'd16;
    p_pool[1] = 64'h0401;                            l_pool[1] = 6'd16;
    p_pool[2] = 64'h0802;                            l_pool[2] = 6'd16;
    p_pool[3] = ref_mask(64'hDEAD_BEEF_CAFE_F00D, 6'd63); l_pool[3] = 6'd63;
    p_pool[4] = 64'h0;                               l_pool[4] = 6'd0;
    p_pool[5] = ref_mask(64'h0123_4567_89AB_CDEF, 6'd40); l_pool[5] = 6'd40;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", any_out(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // New Interest, then aggregation from a second face, then streaming to both faces.
    do_interest(64'h1234, 6'd16, 4'b0001);
    do_interest(64'h1234, 6'd16, 4'b0100);
    do_lookup(64'h1234, 6'd16, 8'd0, 1, -1);
    do_lookup(64'h1234, 6'd16, 8'd0, 1, -1);
    do_lookup(64'hBEEF, 6'd16, 8'd0, 1, -1);

    // Two names folding to the same slot.
    do_interest(64'h0401, 6'd16, 4'b0010);
    do_interest(64'h0802, 6'd16, 4'b1000);

    // Lookup and Interest presented together: lookup goes first.
    phit = model_hit(64'hBEEF, 6'd16, pbm);
    pk = model_interest(64'hC0FFEE, 6'd24, 4'b0010);
    p_rej = -1; p_start = -1; p_ready = -1; p_fib = -1;
    prefix_ready = 1'b1; data_prefix = 64'hBEEF; data_len = 6'd16;
    int_valid = 1'b1; int_prefix = 64'hC0FFEE; int_len = 6'd24; int_face = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (rejected && p_rej < 0) p_rej = k;
      if (start_send_to_pit && p_start < 0) p_start = k;
      if (int_ready && p_ready < 0) p_ready = k;
      if (fib_out_bit && p_fib < 0) p_fib = k;
      @(posedge clk); #1;
      prefix_ready = 1'b0;
      if (p_ready >= 0) int_valid = 1'b0;
    end
    int_valid = 1'b0;
    chk("prio_rejected_at", p_rej, phit ? -1 : 2);
    chk("prio_start_at", p_start, -1);
    chk("prio_int_ready_at", p_ready, 4);
    chk("prio_fib_at", p_fib, (pk == 0) ? 6 : -1);

    do_lookup(64'h0401, 6'd16, 8'($urandom), 5, -1);

    // Reset in the middle of a stream retires everything.
    do_interest(64'hABCD, 6'd16, 4'b0001);
    do_lookup(64'hABCD, 6'd16, 8'($urandom), 3, 500);
    @(posedge clk); #1;
    do_lookup(64'hABCD, 6'd16, 8'd0, 1, -1);

    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 5);
      if ($urandom_range(0, 9) < 6)
        do_interest(p_pool[idx], l_pool[idx], NF'(1 << $urandom_range(0, NF - 1)));
      else
        do_lookup(p_pool[idx], l_pool[idx], 8'($urandom), int'($urandom_range(1, 7)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
